// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared constants, types and helpers for the multiplier scheduler.
//   MUL_LAT_DEFAULT : default multiplier latency in clock edges
//   TAG_ID_W        : storage width of the requester id inside a tag
//   ID_W()          : encoded id width for a given requester count
//   tag_t           : one tag-pipeline stage {valid, id}
package mul_sched_pkg;

    localparam int unsigned MUL_LAT_DEFAULT = 4;

    // Tags carry a fixed-width id so the struct can live in the package;
    // only the low ID_W(N_REQ) bits are ever non-zero.
    localparam int unsigned TAG_ID_W = 8;

    function automatic int unsigned ID_W(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   req    : request vector, N bits
//   ptr    : index where the search starts (highest priority this cycle)
//   gnt    : one-hot grant, or zero when no request is pending
//   gnt_id : encoded index of the granted requester (0 when no grant)
module rr_arbiter
    import mul_sched_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = ID_W(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id
);

    logic        found;
    int unsigned idx;

    // Walk from ptr upward with wrap; the first pending request wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (32'(ptr) + off) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/mul_sched.sv
// mul_sched: round-robin scheduler sharing one pipelined 32-bit multiplier among
// N_REQ requesters. Accepts at most one operand pair per cycle, registers the
// operands into the multiplier and routes each result back to its requester via a
// tag pipeline matched to the multiplier latency.
//   CLK, RSTN            : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (ready is a combinational grant)
//   req_a, req_b         : packed operands, requester i at [32i+31:32i]
//   mul_r1, mul_r2       : registered operands to the multiplier
//   mul_rd               : multiplier result
//   resp_valid/resp_data : one-hot result strobe and result data
//   inflight             : accepted operations not yet returned
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*32-1:0]          req_a,
    input  logic [N_REQ*32-1:0]          req_b,
    output logic [N_REQ-1:0]             req_ready,
    output logic [31:0]                  mul_r1,
    output logic [31:0]                  mul_r2,
    input  logic [31:0]                  mul_rd,
    output logic [N_REQ-1:0]             resp_valid,
    output logic [31:0]                  resp_data,
    output logic [$clog2(MUL_LAT+2)-1:0] inflight
);

    localparam int unsigned IW   = ID_W(N_REQ);
    localparam int unsigned IFW  = $clog2(MUL_LAT + 2);
    localparam int unsigned NSTG = MUL_LAT + 1;

    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_id;
    logic             any_gnt;

    logic [IW-1:0]  ptr_q, ptr_d;
    logic [31:0]    r1_q, r1_d;
    logic [31:0]    r2_q, r2_d;
    tag_t           tag_q [NSTG];
    tag_t           tag_d [NSTG];
    logic [IFW-1:0] inflight_q, inflight_d;
    tag_t           last;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign any_gnt   = |gnt;
    assign req_ready = gnt;
    assign last      = tag_q[NSTG-1];
    assign resp_data = mul_rd;
    assign mul_r1    = r1_q;
    assign mul_r2    = r2_q;
    assign inflight  = inflight_q;

    always_comb begin
        resp_valid = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            resp_valid[i] = last.valid && (last.id == TAG_ID_W'(i));
        end
    end

    always_comb begin
        r1_d = r1_q;
        r2_d = r2_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                r1_d = req_a[32*i +: 32];
                r2_d = req_b[32*i +: 32];
            end
        end

        ptr_d = ptr_q;
        if (any_gnt) begin
            ptr_d = (32'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
        end

        // Stage 0 loads alongside the operand registers; the last stage lines up
        // with mul_rd, so the tag pipeline never stalls.
        tag_d[0] = '{valid: any_gnt, id: TAG_ID_W'(gnt_id)};
        for (int unsigned k = 1; k < NSTG; k++) begin
            tag_d[k] = tag_q[k-1];
        end

        inflight_d = inflight_q;
        case ({any_gnt, last.valid})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ptr_q      <= '0;
            r1_q       <= '0;
            r2_q       <= '0;
            inflight_q <= '0;
            for (int unsigned k = 0; k < NSTG; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            r1_q       <= r1_d;
            r2_q       <= r2_d;
            inflight_q <= inflight_d;
            for (int unsigned k = 0; k < NSTG; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: self-checking bench for mul_sched with a behavioural 4-stage
// multiplier attached. A queue-based model predicts grants, responses and the
// in-flight count every cycle; directed tests add literal expectations.
module tb_mul_sched;

    localparam int N   = 4;
    localparam int LAT = 4;

    logic              CLK = 1'b0;
    logic              RSTN;
    logic [N-1:0]      req_valid;
    logic [N*32-1:0]   req_a;
    logic [N*32-1:0]   req_b;
    logic [N-1:0]      req_ready;
    logic [31:0]       mul_r1;
    logic [31:0]       mul_r2;
    logic [31:0]       mul_rd;
    logic [N-1:0]      resp_valid;
    logic [31:0]       resp_data;
    logic [2:0]        inflight;

    int n_checks = 0;
    int n_err    = 0;

    always #5 CLK = ~CLK;

    mul_sched #(
        .N_REQ   (N),
        .MUL_LAT (LAT)
    ) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .mul_r1     (mul_r1),
        .mul_r2     (mul_r2),
        .mul_rd     (mul_rd),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .inflight   (inflight)
    );

    // Shared multiplier: fully pipelined, no reset, LAT edges of latency.
    logic [31:0] mp [LAT];
    always @(posedge CLK) begin
        mp[0] <= mul_r1 * mul_r2;
        for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
    end
    assign mul_rd = mp[LAT-1];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        int          id;
        logic [31:0] prod;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   m_ptr = 0;

    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int off = 0; off < N; off++) begin
            if (v[(p + off) % N]) return (p + off) % N;
        end
        return -1;
    endfunction

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            q.delete();
            m_ptr = 0;
        end else begin
            int g;
            if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
            g = model_grant(req_valid, m_ptr);
            if (g >= 0) begin
                q.push_back('{due: cyc + LAT + 1, id: g,
                              prod: req_a[g*32 +: 32] * req_b[g*32 +: 32]});
                m_ptr = (g + 1) % N;
            end
            cyc++;
        end
    end

    always @(negedge CLK) begin
        if (RSTN) begin
            int          g;
            logic [31:0] exp_rdy;
            g       = model_grant(req_valid, m_ptr);
            exp_rdy = (g >= 0) ? (32'd1 << g) : 32'd0;
            chk("model_ready", 32'(req_ready), exp_rdy);
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("model_resp_valid", 32'(resp_valid), 32'd1 << q[0].id);
                chk("model_resp_data", resp_data, q[0].prod);
            end else begin
                chk("model_resp_idle", 32'(resp_valid), 32'd0);
            end
            chk("model_inflight", 32'(inflight), 32'(q.size()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input int i, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]     = 1'b1;
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #3;
        RSTN      = 1'b0;
        req_valid = '0;
        @(posedge CLK);
        #3;
        RSTN = 1'b1;
    endtask

    task automatic drain(input int n);
        req_valid = '0;
        for (int c = 0; c < n; c++) tick();
    endtask

    logic [31:0] wa   [3];
    logic [31:0] wb   [3];
    logic [31:0] wexp [3];

    initial begin
        RSTN      = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        wa   = '{32'hFFFF_FFFF, 32'h0001_0000, 32'h1234_5678};
        wb   = '{32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_0009};
        wexp = '{32'h0000_0001, 32'h0000_0000, 32'hA3D7_0A38};

        #2;
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_inflight", 32'(inflight), 32'd0);
        chk("reset_mul_r1", mul_r1, 32'd0);
        chk("reset_mul_r2", mul_r2, 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        @(posedge CLK);
        #3;
        RSTN = 1'b1;

        // Single request: 3*5 on requester 0.
        tick();
        drive(0, 32'd3, 32'd5);
        @(negedge CLK);
        chk("single_ready", 32'(req_ready), 32'd1);
        for (int c = 1; c <= 6; c++) begin
            tick();
            req_valid = '0;
            @(negedge CLK);
            chk("single_inflight", 32'(inflight), (c <= 5) ? 32'd1 : 32'd0);
            if (c == 5) begin
                chk("single_resp_valid", 32'(resp_valid), 32'd1);
                chk("single_resp_data", resp_data, 32'd15);
            end
        end

        // Products that wrap to the low 32 bits.
        for (int c = 0; c < 8; c++) begin
            tick();
            req_valid = '0;
            if (c < 3) drive(c, wa[c], wb[c]);
            @(negedge CLK);
            if (c >= 5) begin
                chk("wrap_resp_valid", 32'(resp_valid), 32'd1 << (c - 5));
                chk("wrap_resp_data", resp_data, wexp[c-5]);
            end
        end
        drain(2);

        // All four requesters continuously valid.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            tick();
            for (int i = 0; i < N; i++) drive(i, 32'(c * 4 + i + 1), 32'(32'h1000 + i * 3));
            @(negedge CLK);
            chk("rr_ready", 32'(req_ready), 32'd1 << (c % 4));
            if (c >= 5) begin
                chk("rr_inflight", 32'(inflight), 32'd5);
                chk("rr_resp_valid", 32'(resp_valid), 32'd1 << ((c - 5) % 4));
            end
        end
        drain(7);

        // Fairness with requesters 1 and 3 only.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            tick();
            drive(1, 32'(c + 2), 32'd7);
            drive(3, 32'(c + 5), 32'd11);
            @(negedge CLK);
            chk("fair_ready", 32'(req_ready), (c % 2 == 0) ? 32'd2 : 32'd8);
        end
        drain(7);

        // Asynchronous reset with operations in flight.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            tick();
            req_valid = '0;
            if (c < 3) drive(0, 32'(c + 2), 32'(c + 11));
            @(negedge CLK);
        end
        chk("midrst_inflight_before", 32'(inflight), 32'd3);
        @(posedge CLK);
        #3;
        RSTN = 1'b0;
        #1;
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_inflight", 32'(inflight), 32'd0);
        chk("midrst_mul_r1", mul_r1, 32'd0);
        chk("midrst_mul_r2", mul_r2, 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        @(posedge CLK);
        #3;
        RSTN = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            @(negedge CLK);
            chk("midrst_no_resp", 32'(resp_valid), 32'd0);
        end
        tick();
        drive(1, 32'd7, 32'd6);
        for (int c = 1; c <= 5; c++) begin
            tick();
            req_valid = '0;
            @(negedge CLK);
        end
        chk("midrst_new_valid", 32'(resp_valid), 32'd2);
        chk("midrst_new_data", resp_data, 32'd42);
        drain(2);

        // Requester 2 every cycle: grant and response coincide from cycle 5.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick();
            drive(2, 32'(c + 1), 32'(c + 3));
            @(negedge CLK);
            if (c >= 5) begin
                chk("simul_ready", 32'(req_ready), 32'd4);
                chk("simul_resp_valid", 32'(resp_valid), 32'd4);
                chk("simul_inflight", 32'(inflight), 32'd5);
            end
        end
        drain(7);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_sched.md
# mul_sched

Round-robin scheduler that shares one fully pipelined 32-bit multiplier (`mul`, low-32-bit product, 4-cycle latency) among `N_REQ` requesters. It accepts at most one operand pair per cycle and drives the registered operands into the multiplier. It tracks each in-flight operation with a tag pipeline aligned to the multiplier latency, and routes each result back to its originating requester. It sits between the execution units that need multiplication and the single shared `mul` instance.

## Interface
- `N_REQ`, default 4: number of requesters; must be ≥2.
- `MUL_LAT`, default 4: clock edges from `mul_r1`/`mul_r2` stable to `mul_rd` stable; must match the multiplier.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RSTN`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester operation request.
- `req_a`  in  N_REQ*32  operand A; requester i occupies bits [32i+31:32i].
- `req_b`  in  N_REQ*32  operand B; same packing as `req_a`.
- `req_ready`  out  N_REQ  one-hot or zero grant, combinational; transfer when `req_valid[i] & req_ready[i]`.
- `mul_r1`  out  32  registered operand A to the multiplier.
- `mul_r2`  out  32  registered operand B to the multiplier.
- `mul_rd`  in  32  multiplier result.
- `resp_valid`  out  N_REQ  one-hot or zero result strobe, one cycle per operation.
- `resp_data`  out  32  result; valid only while `resp_valid` is nonzero.
- `inflight`  out  $clog2(MUL_LAT+2)  number of accepted operations not yet returned.

## Operation
- **Arbitration:** round-robin pointer `ptr`. The grant goes to the first `i` with `req_valid[i]`, searching from `ptr` upward with wrap. `req_ready` is never asserted without the matching `req_valid`.
- **Pointer update:** after a grant to requester g, `ptr` becomes `(g+1) mod N_REQ`. With no grant, `ptr` is unchanged. Reset value of `ptr` is 0.
- **Issue:** on a grant, `mul_r1`/`mul_r2` register that requester's operands. With no grant they hold their previous value. Their content is don't-care because the tag is invalid.
- **Tag pipeline:**
  - Tags have `MUL_LAT+1` stages; each stage holds {valid, id}, with id $clog2(N_REQ) bits wide.
  - Stage 0 loads {grant, g} on the same edge as `mul_r1`. Every stage shifts every cycle; there is no stall.
- **Response:**
  - `resp_valid[id] = last-stage valid`; all other bits are 0.
  - `resp_data = mul_rd`, combinational passthrough.
  - Responses cannot be back-pressured; requesters must always accept them.
- **Arithmetic:** the result is the low 32 bits of the unsigned product; overflow is silently discarded.
- **`inflight`:**
  - +1 on a grant, −1 on `resp_valid`, unchanged when both occur in the same cycle.
  - It never exceeds `MUL_LAT+1`, because one grant per cycle is the structural limit.
- **Reset:** asynchronous assertion clears the following to 0: all tag valids, `ptr`, `inflight`, `mul_r1`, `mul_r2`.
  - No `resp_valid` pulses after reset, even for operations in flight at reset. Their results are dropped.
  - The multiplier itself has no reset; its stale contents are harmless because all tags are invalid.

## Timing
- **Accept to response:** accept in cycle 0 → `mul_r1` stable in cycle 1 → `mul_rd` stable and `resp_valid` high in cycle `1+MUL_LAT` (cycle 5 by default). Total latency is `MUL_LAT+1` cycles.
- **Throughput:** 1 operation per cycle aggregate, with full back-to-back issue.
- **Response ordering:** responses return in acceptance order, including across requesters.
- **Same-cycle events:** a grant and a response in the same cycle are independent; requester i may get `resp_valid[i]` and `req_ready[i]` in the same cycle.
- **Combinational paths:**
  - `req_valid` → `req_ready` is the only combinational path that originates from requester inputs.
  - `mul_rd` → `resp_data` is a passthrough.
- **Reset values:**
  - `req_ready` = 0 when `req_valid` = 0.
  - `resp_valid` = 0, `inflight` = 0, `mul_r1` = 0, `mul_r2` = 0.

## Structure
- **Package `mul_sched_pkg`:** `MUL_LAT` default constant, `ID_W` function ($clog2), and tag struct {valid, id}.
- **Sub-module `rr_arbiter`:** parameter N; inputs `req` and `ptr`; outputs one-hot `gnt` and encoded `gnt_id`. Purely combinational.
- **`mul_sched`:** holds `ptr`, operand registers, the tag shift register and the `inflight` counter.
- **Bench:** instantiates `mul_sched` with the real `mul` connected through `mul_r1`/`mul_r2`/`mul_rd`.

## Test plan
- **Single request:** requester 0 sends a=3, b=5 in cycle 0 → `req_ready[0]` in cycle 0; `resp_valid`=4'b0001 with `resp_data`=15 in cycle 5; `inflight` reads 1 in cycles 1–5 and 0 in cycle 6.
- **Wrap to low bits:** a=0xFFFFFFFF, b=0xFFFFFFFF → 0x00000001; a=0x00010000, b=0x00010000 → 0x00000000; a=0x12345678, b=0x9 → 0xA3D70A38.
- **All four requesters continuous with distinct operands:**
  - Grants go 0,1,2,3,0,… on consecutive cycles.
  - Responses arrive 5 cycles after each grant, in the same order and with the correct products.
  - `inflight` saturates at 5.
- **Fairness:** requesters 1 and 3 continuously valid, 0 and 2 idle → grants alternate 1,3,1,3; the pointer skips idle requesters.
- **Reset mid-flight:** issue 3 operations, then assert `RSTN` low asynchronously between edges two cycles later → all outputs 0 immediately; after release, no `resp_valid` pulses, and a new request returns correctly 5 cycles after acceptance.
- **Simultaneous grant and response:** requester 2 issues every cycle → from cycle 5 onward, `req_ready[2]` and `resp_valid[2]` are high together each cycle and `inflight` holds at 5.
